// File: rtl/jk_ctrl_pkg.sv
// Shared definitions for the JK bank controller: command encodings, FSM state type and the
// command-to-{J,K} mapping used to drive a cell.
package jk_ctrl_pkg;

    // Command encoding is the {J,K} pair itself
    localparam logic [1:0] OpHold = 2'b00;
    localparam logic [1:0] OpClr  = 2'b01;
    localparam logic [1:0] OpSet  = 2'b10;
    localparam logic [1:0] OpTgl  = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StAck
    } state_e;

    // Returns {J,K} for a command
    function automatic logic [1:0] op_to_jk(input logic [1:0] op);
        logic [1:0] jk;
        case (op)
            OpHold:  jk = 2'b00;
            OpClr:   jk = 2'b01;
            OpSet:   jk = 2'b10;
            default: jk = 2'b11;
        endcase
        return jk;
    endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop built on an SR core. The JK-to-SR mapping S = J & ~q, R = K & q means
// the SR stage can never see S = R = 1, so every J/K combination is a legal drive.
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset, clears the cell
//   j_i    : J input
//   k_i    : K input
//   q_o    : stored bit
module jk_cell (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic j_i,
    input  logic k_i,
    output logic q_o
);

    logic q_q;
    logic q_d;
    logic s;
    logic r;

    always_comb begin
        s   = j_i & ~q_q;
        r   = k_i & q_q;
        q_d = q_q;
        if (s) begin
            q_d = 1'b1;
        end else if (r) begin
            q_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/jk_bank_ctrl.sv
// Round-robin command controller sharing a bank of WIDTH JK cells among NREQ requesters.
// Each transaction runs IDLE (arbitrate + latch) -> EXEC (drive one cell) -> ACK (pulse).
//   clk      : clock, rising edge
//   rst      : asynchronous active-low reset
//   req      : per-requester request level
//   op       : per-requester command, slice i = op[2i+1:2i]
//   addr     : per-requester cell index, slice i = addr[AW*i +: AW]
//   ack      : one-cycle completion pulse to the served requester
//   rdata    : addressed cell value after the update, valid while ack is nonzero
//   grant_id : index of the requester being served
//   busy     : high in EXEC and ACK
//   q        : live bank contents
module jk_bank_ctrl
    import jk_ctrl_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = $clog2(WIDTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [2*NREQ-1:0]        op,
    input  logic [AW*NREQ-1:0]       addr,
    output logic [NREQ-1:0]          ack,
    output logic                     rdata,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     busy,
    output logic [WIDTH-1:0]         q
);

    localparam int unsigned IW = $clog2(NREQ);

    state_e          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   grant_q, grant_d;
    logic [1:0]      op_q, op_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic            rdata_q, rdata_d;
    logic            busy_q, busy_d;

    logic            found;
    logic [IW-1:0]   pick;
    logic [IW-1:0]   idx;
    logic [1:0]      jk;
    logic            in_range;
    logic            cur_bit;
    logic            new_bit;
    logic [WIDTH-1:0] j_vec;
    logic [WIDTH-1:0] k_vec;

    // First set request at or above the pointer, wrapping around
    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        idx   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = IW'((32'(ptr_q) + i) % NREQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // Cell drive: only the latched cell sees the latched op, and only in EXEC
    always_comb begin
        jk       = op_to_jk(op_q);
        in_range = 32'(addr_q) < WIDTH;
        cur_bit  = 1'b0;
        j_vec    = '0;
        k_vec    = '0;
        for (int unsigned c = 0; c < WIDTH; c++) begin
            if (32'(addr_q) == c) begin
                cur_bit = q[c];
                if (state_q == StExec) begin
                    j_vec[c] = jk[1];
                    k_vec[c] = jk[0];
                end
            end
        end
        // Value the cell will hold after the EXEC edge, so rdata lines up with ack
        new_bit = (jk[1] & ~cur_bit) ? 1'b1 : ((jk[0] & cur_bit) ? 1'b0 : cur_bit);
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        op_d    = op_q;
        addr_d  = addr_q;
        ack_d   = '0;
        rdata_d = rdata_q;
        busy_d  = busy_q;
        case (state_q)
            StIdle: begin
                if (found) begin
                    state_d = StExec;
                    grant_d = pick;
                    busy_d  = 1'b1;
                    for (int unsigned i = 0; i < NREQ; i++) begin
                        if (IW'(i) == pick) begin
                            op_d   = op[2*i +: 2];
                            addr_d = addr[AW*i +: AW];
                        end
                    end
                end
            end
            StExec: begin
                state_d        = StAck;
                busy_d         = 1'b1;
                ack_d[grant_q] = 1'b1;
                rdata_d        = in_range ? new_bit : 1'b0;
            end
            StAck: begin
                state_d = StIdle;
                busy_d  = 1'b0;
                ptr_d   = (32'(grant_q) == NREQ - 1) ? '0 : grant_q + 1'b1;
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            grant_q <= '0;
            op_q    <= OpHold;
            addr_q  <= '0;
            ack_q   <= '0;
            rdata_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
        end
    end

    for (genvar c = 0; c < WIDTH; c++) begin : g_cell
        jk_cell u_cell (
            .clk_i  (clk),
            .rst_ni (rst),
            .j_i    (j_vec[c]),
            .k_i    (k_vec[c]),
            .q_o    (q[c])
        );
    end

    assign ack      = ack_q;
    assign rdata    = rdata_q;
    assign grant_id = grant_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Self-checking bench for jk_bank_ctrl: a WIDTH=8 instance for the main traffic and a WIDTH=6
// instance for out-of-range addresses. Expected acks are queued at drive time and popped when
// the DUT pulses ack.
module tb_jk_bank_ctrl;
    import jk_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [7:0]  op;
    logic [11:0] addr;
    logic [3:0]  ack;
    logic        rdata;
    logic [1:0]  grant_id;
    logic        busy;
    logic [7:0]  q;

    logic [3:0]  req6;
    logic [7:0]  op6;
    logic [11:0] addr6;
    logic [3:0]  ack6;
    logic        rdata6;
    logic [1:0]  grant6;
    logic        busy6;
    logic [5:0]  q6;

    always #5 clk = ~clk;

    jk_bank_ctrl #(.NREQ(4), .WIDTH(8)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .op       (op),
        .addr     (addr),
        .ack      (ack),
        .rdata    (rdata),
        .grant_id (grant_id),
        .busy     (busy),
        .q        (q)
    );

    jk_bank_ctrl #(.NREQ(4), .WIDTH(6)) u_dut6 (
        .clk      (clk),
        .rst      (rst),
        .req      (req6),
        .op       (op6),
        .addr     (addr6),
        .ack      (ack6),
        .rdata    (rdata6),
        .grant_id (grant6),
        .busy     (busy6),
        .q        (q6)
    );

    typedef struct {
        int         idx;
        logic [1:0] op;
        int         addr;
        logic       rdata;
        logic [7:0] q;
    } vec_t;

    typedef struct {
        logic [3:0] ack;
        logic [1:0] grant;
        logic       rdata;
        logic [7:0] q;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[8];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] a, input logic [1:0] g, input logic r,
                        input logic [7:0] qq);
        exp_t e;
        e.ack   = a;
        e.grant = g;
        e.rdata = r;
        e.q     = qq;
        sb.push_back(e);
    endtask

    task automatic drive(input bit use6, input int idx, input logic [1:0] o, input int a);
        logic [2:0] a3;
        a3 = a[2:0];
        if (use6) begin
            req6[idx]          = 1'b1;
            op6[2*idx +: 2]    = o;
            addr6[3*idx +: 3]  = a3;
        end else begin
            req[idx]           = 1'b1;
            op[2*idx +: 2]     = o;
            addr[3*idx +: 3]   = a3;
        end
    endtask

    // Waits (bounded) for an ack pulse, then compares it against the oldest queued expectation
    task automatic wait_ack(input bit use6, input string name);
        exp_t       e;
        int         n   = 0;
        bit         got = 1'b0;
        logic [3:0] a;
        while (n < 10 && !got) begin
            a = use6 ? ack6 : ack;
            if (a != 4'b0) got = 1'b1;
            else begin
                tick();
                n++;
            end
        end
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, got ack %0h expected none", name, a);
        end else begin
            e = sb.pop_front();
            if (!got) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s: ack timeout, got 0 expected %0h", name, e.ack);
            end else begin
                check({name, "_ack"},   32'(use6 ? ack6 : ack), 32'(e.ack));
                check({name, "_grant"}, 32'(use6 ? grant6 : grant_id), 32'(e.grant));
                check({name, "_rdata"}, 32'(use6 ? rdata6 : rdata), 32'(e.rdata));
                check({name, "_q"},     use6 ? 32'(q6) : 32'(q), 32'(e.q));
                tick();
            end
        end
    endtask

    task automatic do_reset(input string name);
        rst = 1'b0;
        #1;
        check({name, "_q"},    32'(q), 32'h0);
        check({name, "_ack"},  32'(ack), 32'h0);
        check({name, "_busy"}, 32'(busy), 32'h0);
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] m;
        int         seen;

        tbl[0] = '{0, OpSet,  3, 1'b1, 8'h08};
        tbl[1] = '{1, OpTgl,  5, 1'b1, 8'h28};
        tbl[2] = '{2, OpTgl,  5, 1'b0, 8'h08};
        tbl[3] = '{3, OpClr,  5, 1'b0, 8'h08};
        tbl[4] = '{1, OpHold, 3, 1'b1, 8'h08};
        tbl[5] = '{2, OpClr,  3, 1'b0, 8'h00};
        tbl[6] = '{3, OpSet,  7, 1'b1, 8'h80};
        tbl[7] = '{0, OpTgl,  0, 1'b1, 8'h81};

        rst = 1'b0; req = '0; op = '0; addr = '0;
        req6 = '0; op6 = '0; addr6 = '0;
        #2;
        check("rst_q",     32'(q), 32'h0);
        check("rst_ack",   32'(ack), 32'h0);
        check("rst_busy",  32'(busy), 32'h0);
        check("rst_rdata", 32'(rdata), 32'h0);
        check("rst_grant", 32'(grant_id), 32'h0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Single-requester commands from the table
        for (int i = 0; i < 8; i++) begin
            push(4'(1 << tbl[i].idx), 2'(tbl[i].idx), tbl[i].rdata, tbl[i].q);
            drive(1'b0, tbl[i].idx, tbl[i].op, tbl[i].addr);
            tick();
            check("exec_busy", 32'(busy), 32'h1);
            check("exec_ack",  32'(ack), 32'h0);
            req = '0;
            wait_ack(1'b0, "tbl");
            check("idle_busy", 32'(busy), 32'h0);
        end

        // Mid-run reset clears a nonzero bank
        do_reset("midrst");

        // Round-robin with all requests held
        req  = 4'hF;
        op   = 8'hFF;
        addr = {3'd3, 3'd2, 3'd1, 3'd0};
        m = 8'h00;
        for (int k = 0; k < 5; k++) begin
            m[k % 4] = ~m[k % 4];
            push(4'(1 << (k % 4)), 2'(k % 4), m[k % 4], m);
        end
        for (int k = 0; k < 5; k++) wait_ack(1'b0, "rr");
        req = '0; op = '0; addr = '0;
        tick();
        tick();

        // Requester 2 drops req in EXEC, other inputs scrambled: still completes
        push(4'b0100, 2'd2, 1'b1, 8'h1E);
        drive(1'b0, 2, OpSet, 4);
        tick();
        req  = '0;
        op   = 8'h55;
        addr = 12'hFFF;
        wait_ack(1'b0, "drop");
        op = '0; addr = '0;
        tick();

        // Reset during EXEC aborts the transaction
        drive(1'b0, 1, OpSet, 6);
        tick();
        req = '0;
        rst = 1'b0;
        #1;
        check("abort_q",     32'(q), 32'h0);
        check("abort_ack",   32'(ack), 32'h0);
        check("abort_busy",  32'(busy), 32'h0);
        check("abort_grant", 32'(grant_id), 32'h0);
        tick();
        tick();
        rst = 1'b1;
        op = '0; addr = '0;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (ack != 4'b0) seen++;
        end
        check("abort_noack", 32'(seen), 32'h0);
        check("abort_bit6",  32'(q[6]), 32'h0);

        // Pointer back at 0 after reset: 1010 must grant requester 1
        push(4'b0010, 2'd1, 1'b0, 8'h00);
        req = 4'b1010;
        tick();
        req = '0;
        wait_ack(1'b0, "ptr0");

        // Out-of-range addresses on the WIDTH=6 bank
        push(4'b0001, 2'd0, 1'b1, 8'h20);
        drive(1'b1, 0, OpSet, 5);
        tick();
        req6 = '0;
        wait_ack(1'b1, "w6_set5");
        push(4'b0001, 2'd0, 1'b0, 8'h20);
        drive(1'b1, 0, OpSet, 7);
        tick();
        req6 = '0;
        wait_ack(1'b1, "w6_oor7");
        push(4'b0001, 2'd0, 1'b0, 8'h20);
        drive(1'b1, 0, OpTgl, 6);
        tick();
        req6 = '0;
        wait_ack(1'b1, "w6_oor6");

        check("sb_empty", 32'(sb.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/jk_bank_ctrl.md
# jk_bank_ctrl

Round-robin command controller that shares a bank of `WIDTH` JK flip-flop cells among `NREQ` requesters. Each requester issues one bit-level command (hold, clear, set, toggle) with a request/acknowledge handshake. The controller arbitrates, drives J/K for exactly one clock edge on the addressed cell, and returns the post-update bit value. It is the sequencing layer above the JK cells built in this flip-flop library, and it guarantees that no cell ever receives an illegal drive.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `WIDTH`, 8: number of JK cells in the bank.
- `AW`, `$clog2(WIDTH)`: cell address width (derived; do not override).
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req`  in  NREQ  per-requester request level.
- `op`  in  2*NREQ  per-requester command, slice i = `op[2i+1:2i]`.
- `addr`  in  AW*NREQ  per-requester cell index, slice i = `addr[AW*i +: AW]`.
- `ack`  out  NREQ  one-cycle completion pulse to the served requester.
- `rdata`  out  1  addressed cell value after the update; valid while `ack` is nonzero.
- `grant_id`  out  $clog2(NREQ)  index of the requester being served.
- `busy`  out  1  high in EXEC and ACK.
- `q`  out  WIDTH  live bank contents.

## Operation
- Op encoding (J,K): HOLD=00 (0,0), CLR=01 (0,1), SET=10 (1,0), TGL=11 (1,1).
- Reset (`rst`=0, asynchronous) forces: `q`=0, `ack`=0, `rdata`=0, `grant_id`=0, `busy`=0, FSM=IDLE, round-robin pointer=0.
- FSM states:
  - IDLE: if any `req` bit is set, select the first set bit scanning from pointer upward with wrap. Latch that index, its `op` and its `addr`, then go to EXEC. Otherwise stay in IDLE.
  - EXEC: drive J/K of the latched cell from the latched op. All other cells get J=K=0. The cell updates on the edge leaving EXEC. Next state is ACK.
  - ACK: `ack[grant_id]`=1 and `rdata`=`q[addr]` (new value). Pointer becomes (grant_id+1) mod NREQ. Next state is IDLE.
- Inputs are sampled only in IDLE. Changes to `req`, `op` or `addr` during EXEC/ACK have no effect on the transaction in flight.
- If a requester drops `req` after it is latched, its transaction still completes and `ack` still pulses.
- A requester must deassert `req` in the cycle after it sees `ack`. If it keeps `req` high, that is a new request; it is only served again after the other pending requesters, because the pointer has advanced.
- `addr` ≥ WIDTH (non-power-of-two WIDTH): no cell changes, `ack` still pulses, `rdata`=0.
- The cell's internal SR stage never sees S=R=1; this is guaranteed by the JK-to-SR mapping S=J&~q, R=K&q.
- Reset asserted during EXEC or ACK: the transaction is aborted, no `ack` is issued, and `q` clears.

## Timing
- Request-to-ack latency: 2 cycles. With `req` sampled at edge n (IDLE→EXEC), the cell updates at edge n+1 and `ack` is high during cycle n+1..n+2.
- Maximum throughput: one command per 3 cycles.
- `ack`, `rdata`, `grant_id` and `busy` are registered outputs with no combinational path from the inputs.
- `q` reflects the cell flops directly.

## Structure
- Package `jk_ctrl_pkg`:
  - op encoding localparams (HOLD, CLR, SET, TGL);
  - FSM state typedef (IDLE, EXEC, ACK);
  - function mapping op to {J,K}.
- Sub-module `jk_cell`: a single JK flip-flop built from an SR core (S=J&~q, R=K&q), with async active-low reset, instantiated WIDTH times.
- Arbiter, latch registers and FSM live in `jk_bank_ctrl`.

## Test plan
- Reset: hold `rst`=0 mid-run -> `q`=0x00, `ack`=0, `busy`=0 immediately. After release, IDLE with pointer=0.
- Single command: req0 with SET, addr=3 -> `busy` high for 2 cycles, `q`=0x08, `ack`=0001 with `rdata`=1 two cycles after sampling.
- Round-robin: req=1111 held continuously, all ops TGL, addrs 0..3 -> grants in order 0,1,2,3,0. Final `q` after the first four acks is 0x0F.
- Toggle and clear: TGL on addr 5 twice, then CLR -> `rdata` sequence 1, 0, 0, and `q[5]`=0.
- Drop and race: req2 dropped in EXEC -> `ack`=0100 still pulses. Reset asserted in EXEC of a SET -> no `ack`, and the bit stays 0.
- Out-of-range address (WIDTH=6): SET addr=7 -> `q` unchanged, `ack` pulses, `rdata`=0.
